wb_arbiter: RTL and testbench

//  Writeback arbiter directly upstream of the register file write port (WA/WD/WE1).

---
 rtl/wb_arbiter.sv | 95 +++++++++
 tb/tb_wb_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU result stream with a queued load-result stream
// into one registered register-file write per cycle, with bounded load starvation.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_W-1:0]             alu_addr,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  input  logic [ADDR_W-1:0]             q_addr,
  output logic                          q_hit,
  output logic [$clog2(FIFO_DEPTH):0]   ld_count,
  output logic [ADDR_W-1:0]             WA,
  output logic [DATA_W-1:0]             WD,
  output logic                          WE1
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;
  logic              empty, full, starved, alu_grant, push, pop;
  logic [FIFO_DEPTH-1:0] hit_vec;

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign starved   = !empty && (starve_cnt == SW'(STARVE_MAX));
  assign alu_ready = !starved;
  assign alu_grant = alu_valid && !starved;
  // Pop looks only at the current head; an entry pushed this cycle is not yet visible.
  assign pop       = !alu_grant && !empty;
  assign ld_ready  = !full;
  assign push      = ld_valid && ld_ready;
  assign ld_count  = count;

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_hit
    logic [PW-1:0] off;
    assign off        = PW'(g) - rd_ptr;
    assign hit_vec[g] = ({1'b0, off} < count) && (mem_addr[g] == q_addr);
  end
  assign q_hit = (|hit_vec) || (WE1 && (WA == q_addr));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= ld_addr;
      mem_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      WE1        <= 1'b0;
      WA         <= '0;
      WD         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop || empty)
        starve_cnt <= '0;
      else if (alu_grant && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      WE1 <= alu_grant || pop;
      if (alu_grant) begin
        WA <= alu_addr;
        WD <= alu_data;
      end else if (pop) begin
        WA <= mem_addr[rd_ptr];
        WD <= mem_data[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU path, fill/starvation pattern, full+pop,
// hazard query, mid-stream reset and back-to-back traffic.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [5:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic [5:0]  q_addr;
  logic        q_hit;
  logic [2:0]  ld_count;
  logic [5:0]  WA;
  logic [31:0] WD;
  logic        WE1;

  int checks = 0;
  int errors = 0;

  wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .q_addr(q_addr), .q_hit(q_hit), .ld_count(ld_count),
    .WA(WA), .WD(WD), .WE1(WE1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_addr = '0; alu_data = '0;
    ld_valid = 0; ld_addr = '0; ld_data = '0; q_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0; step(); rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    ld_valid = 1; ld_addr = 6'd7; ld_data = 32'h77;
    rst_n = 0; step(); step();
    checks++; if (WE1 !== 1'b0) begin errors++; $display("FAIL reset_we1 got %b want 0", WE1); end
    checks++; if (ld_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ld_count); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
    checks++; if (WA !== 6'd0 || WD !== 32'd0) begin errors++; $display("FAIL reset_wa_wd got %0d/%h want 0/0", WA, WD); end
    rst_n = 1; ld_valid = 0; step();
  endtask

  task automatic test_alu_only();
    do_reset();
    alu_valid = 1; alu_addr = 6'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 0;
    checks++; if (WE1 !== 1'b1 || WA !== 6'd5 || WD !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write got we=%b wa=%0d wd=%h want 1/5/deadbeef", WE1, WA, WD); end
    step();
    checks++; if (WE1 !== 1'b0 || WA !== 6'd5 || WD !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_idle got we=%b wa=%0d wd=%h want 0/5/deadbeef (held)", WE1, WA, WD); end
  endtask

  task automatic test_fill();
    logic [5:0] exp_wa [18] = '{20,21,22,23,1,25,26,27,2,29,30,31,3,33,34,35,4,37};
    logic [31:0] exp_wd;
    logic exp_ar;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      alu_valid = 1; alu_addr = 6'(20 + c); alu_data = 32'hA000 + 32'(c);
      ld_valid = (c < 4); ld_addr = 6'(c + 1); ld_data = 32'h100 + 32'(c + 1);
      #1;
      exp_ar = !(c == 4 || c == 8 || c == 12 || c == 16);
      checks++; if (alu_ready !== exp_ar) begin
        errors++; $display("FAIL fill_alu_ready c=%0d got %b want %b", c, alu_ready, exp_ar); end
      if (c == 4) begin
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b want 0", ld_ready); end
      end
      @(posedge clk); #1;
      if (c == 3) begin
        checks++; if (ld_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", ld_count); end
      end
      exp_wd = (exp_wa[c] < 20) ? 32'h100 + 32'(exp_wa[c]) : 32'hA000 + 32'(exp_wa[c] - 20);
      checks++; if (WE1 !== 1'b1 || WA !== exp_wa[c] || WD !== exp_wd) begin
        errors++; $display("FAIL fill_write c=%0d got we=%b wa=%0d wd=%h want 1/%0d/%h", c, WE1, WA, WD, exp_wa[c], exp_wd); end
    end
    idle_inputs(); step();
    checks++; if (WE1 !== 1'b0 || ld_count !== 3'd0) begin
      errors++; $display("FAIL fill_drained got we=%b count=%0d want 0/0", WE1, ld_count); end
  endtask

  task automatic test_full_pop();
    logic [5:0] exp_wa [3] = '{6, 7, 8};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1; alu_addr = 6'd40; alu_data = 32'h40;
      ld_valid = 1; ld_addr = 6'(5 + c); ld_data = 32'h500 + 32'(c);
      step();
    end
    ld_addr = 6'd9; ld_data = 32'h999;
    #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready got %b want 0", ld_ready); end
    @(posedge clk); #1;
    checks++; if (ld_count !== 3'd3) begin errors++; $display("FAIL fullpop_count got %0d want 3", ld_count); end
    checks++; if (WE1 !== 1'b1 || WA !== 6'd5 || WD !== 32'h500) begin
      errors++; $display("FAIL fullpop_write got we=%b wa=%0d wd=%h want 1/5/500", WE1, WA, WD); end
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (WE1 !== 1'b1 || WA !== exp_wa[c]) begin
        errors++; $display("FAIL fullpop_drain c=%0d got we=%b wa=%0d want 1/%0d", c, WE1, WA, exp_wa[c]); end
    end
    step();
    checks++; if (WE1 !== 1'b0 || ld_count !== 3'd0) begin
      errors++; $display("FAIL fullpop_no_extra got we=%b count=%0d want 0/0", WE1, ld_count); end
  endtask

  task automatic test_hazard();
    do_reset();
    alu_valid = 1; alu_addr = 6'd12; alu_data = 32'h12;
    ld_valid = 1; ld_addr = 6'd9; ld_data = 32'h9;
    step();
    ld_valid = 0; alu_valid = 0;
    q_addr = 6'd9; #1;
    checks++; if (q_hit !== 1'b1) begin errors++; $display("FAIL hazard_queued got %b want 1", q_hit); end
    q_addr = 6'd10; #1;
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL hazard_other_q got %b want 0", q_hit); end
    q_addr = 6'd12; #1;
    checks++; if (q_hit !== 1'b1) begin errors++; $display("FAIL hazard_wa_alu got %b want 1", q_hit); end
    @(posedge clk); #1;
    q_addr = 6'd9; #1;
    checks++; if (q_hit !== 1'b1 || WE1 !== 1'b1 || WA !== 6'd9) begin
      errors++; $display("FAIL hazard_writing got hit=%b we=%b wa=%0d want 1/1/9", q_hit, WE1, WA); end
    q_addr = 6'd10; #1;
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL hazard_other_w got %b want 0", q_hit); end
    @(posedge clk); #1;
    q_addr = 6'd9; #1;
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL hazard_done got %b want 0", q_hit); end
    // address 0 is an ordinary register
    alu_valid = 1; alu_addr = 6'd1; ld_valid = 1; ld_addr = 6'd0;
    step();
    alu_valid = 0; ld_valid = 0; q_addr = 6'd0; #1;
    checks++; if (q_hit !== 1'b1) begin errors++; $display("FAIL hazard_addr0 got %b want 1", q_hit); end
    step(); step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_addr = 6'd30; alu_data = 32'h30;
      ld_valid = 1; ld_addr = 6'(1 + c); ld_data = 32'h1;
      step();
    end
    checks++; if (ld_count !== 3'd3) begin errors++; $display("FAIL midrst_pre_count got %0d want 3", ld_count); end
    rst_n = 0; step(); rst_n = 1;
    checks++; if (ld_count !== 3'd0 || WE1 !== 1'b0 || WA !== 6'd0) begin
      errors++; $display("FAIL midrst_state got count=%0d we=%b wa=%0d want 0/0/0", ld_count, WE1, WA); end
    idle_inputs(); step();
    checks++; if (WE1 !== 1'b0 || ld_count !== 3'd0) begin
      errors++; $display("FAIL midrst_no_write got we=%b count=%0d want 0/0", WE1, ld_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_addr = 6'(50 + c); alu_data = 32'hB00 + 32'(c);
      step();
      checks++; if (WE1 !== 1'b1 || WA !== 6'(50 + c) || WD !== 32'hB00 + 32'(c)) begin
        errors++; $display("FAIL b2b_alu c=%0d got we=%b wa=%0d wd=%h", c, WE1, WA, WD); end
    end
    alu_valid = 0;
    ld_valid = 1; ld_addr = 6'd3; ld_data = 32'h33;
    step();
    checks++; if (ld_count !== 3'd1 || WE1 !== 1'b0) begin
      errors++; $display("FAIL b2b_push got count=%0d we=%b want 1/0", ld_count, WE1); end
    ld_addr = 6'd4; ld_data = 32'h44;
    step();
    checks++; if (ld_count !== 3'd1 || WE1 !== 1'b1 || WA !== 6'd3 || WD !== 32'h33) begin
      errors++; $display("FAIL b2b_pushpop got count=%0d we=%b wa=%0d wd=%h want 1/1/3/33", ld_count, WE1, WA, WD); end
    ld_valid = 0;
    step();
    checks++; if (ld_count !== 3'd0 || WE1 !== 1'b1 || WA !== 6'd4 || WD !== 32'h44) begin
      errors++; $display("FAIL b2b_last got count=%0d we=%b wa=%0d wd=%h want 0/1/4/44", ld_count, WE1, WA, WD); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_alu_only();
    test_fill();
    test_full_pop();
    test_hazard();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
